// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch master and core.
// Opcode classes, operand decode helper and fetch FSM states.
package cpu_isa_pkg;

    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_LDA  = 3'b010;
    localparam logic [2:0] OPC_LDB  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;

    typedef enum logic [2:0] {
        S_FETCH_OP,
        S_FETCH_ARG,
        S_VALID,
        S_HALT,
        S_ST_SETUP,
        S_ST_WRITE,
        S_ST_DONE
    } fetch_state_t;

    function automatic logic has_operand(input logic [2:0] opc);
        case (opc)
            OPC_LDA, OPC_LDB, OPC_STR: return 1'b1;
            OPC_ADD, OPC_HALT:         return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_fetch_master_if.sv
// Memory bus, instruction handshake and store request bundle.
// master = fetch unit, slave = memory/core side.
interface instr_fetch_master_if;

    logic [7:0] mem_address;
    logic       mem_write;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic [7:0] instr_pc;
    logic       st_req;
    logic [7:0] st_addr;
    logic [7:0] st_data;
    logic       st_ack;

    modport master (
        output mem_address, mem_write, mem_wdata,
        input  mem_rdata,
        output instr_valid, instr_opcode, instr_operand, instr_pc,
        input  instr_ready,
        input  st_req, st_addr, st_data,
        output st_ack
    );

    modport slave (
        input  mem_address, mem_write, mem_wdata,
        output mem_rdata,
        input  instr_valid, instr_opcode, instr_operand, instr_pc,
        output instr_ready,
        output st_req, st_addr, st_data,
        input  st_ack
    );

endinterface

// File: rtl/instr_fetch_master.sv
// Instruction fetch / byte store master for the 256x8 memory.
// All memory-side outputs are registered.
module instr_fetch_master
    import cpu_isa_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                        clk,
    input  logic                        reset,
    instr_fetch_master_if.master        io_bus,
    input  logic                        i_pc_load,
    input  logic [7:0]                  i_pc_load_value,
    output logic                        o_halted
);

    fetch_state_t r_state, w_state;
    logic [7:0]   r_pc, w_pc;
    logic [7:0]   r_addr, w_addr;
    logic         r_write, w_write;
    logic [7:0]   r_wdata, w_wdata;
    logic [7:0]   r_opcode, w_opcode;
    logic [7:0]   r_operand, w_operand;
    logic [7:0]   r_ipc, w_ipc;
    logic         r_st_ack, w_st_ack;
    logic         r_halted, w_halted;
    logic         r_pend_load, w_pend_load;
    logic [7:0]   r_pend_pc, w_pend_pc;
    logic [7:0]   w_pc_inc;

    assign w_pc_inc = r_pc + 8'd1;
    assign w_write  = (w_state == S_ST_WRITE);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH_OP;
        else       r_state <= w_state;
    end

    // Next state and next values of every datapath register
    always_comb begin
        w_state     = r_state;
        w_pc        = r_pc;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_opcode    = r_opcode;
        w_operand   = r_operand;
        w_ipc       = r_ipc;
        w_halted    = r_halted;
        w_pend_load = r_pend_load;
        w_pend_pc   = r_pend_pc;
        w_st_ack    = 1'b0;
        unique case (r_state)
            S_FETCH_OP: begin
                if (i_pc_load) begin
                    w_pc   = i_pc_load_value;
                    w_addr = i_pc_load_value;
                end else if (io_bus.st_req) begin
                    w_addr  = io_bus.st_addr;
                    w_wdata = io_bus.st_data;
                    w_state = S_ST_SETUP;
                end else begin
                    w_opcode  = io_bus.mem_rdata;
                    w_operand = 8'h00;
                    w_ipc     = r_pc;
                    w_pc      = w_pc_inc;
                    w_addr    = w_pc_inc;
                    w_state   = has_operand(io_bus.mem_rdata[7:5])
                              ? S_FETCH_ARG : S_VALID;
                end
            end
            S_FETCH_ARG: begin
                if (i_pc_load) begin
                    w_pc    = i_pc_load_value;
                    w_addr  = i_pc_load_value;
                    w_state = S_FETCH_OP;
                end else begin
                    w_operand = io_bus.mem_rdata;
                    w_pc      = w_pc_inc;
                    w_addr    = w_pc_inc;
                    w_state   = S_VALID;
                end
            end
            S_VALID: begin
                if (i_pc_load) begin
                    w_pc    = i_pc_load_value;
                    w_addr  = i_pc_load_value;
                    w_state = S_FETCH_OP;
                end else if (io_bus.instr_ready) begin
                    if (r_opcode[7:5] == OPC_HALT) begin
                        w_halted = 1'b1;
                        w_state  = S_HALT;
                    end else begin
                        w_state = S_FETCH_OP;
                    end
                end
            end
            S_HALT: begin
                if (i_pc_load) begin
                    w_pc     = i_pc_load_value;
                    w_addr   = i_pc_load_value;
                    w_halted = 1'b0;
                    w_state  = S_FETCH_OP;
                end else if (io_bus.st_req) begin
                    w_addr  = io_bus.st_addr;
                    w_wdata = io_bus.st_data;
                    w_state = S_ST_SETUP;
                end
            end
            S_ST_SETUP, S_ST_WRITE: begin
                if (i_pc_load) begin
                    w_pend_load = 1'b1;
                    w_pend_pc   = i_pc_load_value;
                end
                w_st_ack = (r_state == S_ST_WRITE);
                w_state  = (r_state == S_ST_SETUP)
                         ? S_ST_WRITE : S_ST_DONE;
            end
            S_ST_DONE: begin
                if (i_pc_load || r_pend_load) begin
                    w_pc        = i_pc_load ? i_pc_load_value : r_pend_pc;
                    w_addr      = w_pc;
                    w_halted    = 1'b0;
                    w_pend_load = 1'b0;
                    w_state     = S_FETCH_OP;
                end else begin
                    w_addr  = r_pc;
                    w_state = r_halted ? S_HALT : S_FETCH_OP;
                end
            end
            default: w_state = S_FETCH_OP;
        endcase
    end

    // Datapath and memory-side output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_addr      <= RESET_PC;
            r_write     <= 1'b0;
            r_wdata     <= 8'h00;
            r_opcode    <= 8'h00;
            r_operand   <= 8'h00;
            r_ipc       <= 8'h00;
            r_st_ack    <= 1'b0;
            r_halted    <= 1'b0;
            r_pend_load <= 1'b0;
            r_pend_pc   <= 8'h00;
        end else begin
            r_pc        <= w_pc;
            r_addr      <= w_addr;
            r_write     <= w_write;
            r_wdata     <= w_wdata;
            r_opcode    <= w_opcode;
            r_operand   <= w_operand;
            r_ipc       <= w_ipc;
            r_st_ack    <= w_st_ack;
            r_halted    <= w_halted;
            r_pend_load <= w_pend_load;
            r_pend_pc   <= w_pend_pc;
        end
    end

    assign io_bus.mem_address   = r_addr;
    assign io_bus.mem_write     = r_write;
    assign io_bus.mem_wdata     = r_wdata;
    assign io_bus.instr_valid   = (r_state == S_VALID);
    assign io_bus.instr_opcode  = r_opcode;
    assign io_bus.instr_operand = r_operand;
    assign io_bus.instr_pc      = r_ipc;
    assign io_bus.st_ack        = r_st_ack;
    assign o_halted             = r_halted;

endmodule
